lut_cfg_loader: RTL
===================

# lut_cfg_loader

Serial configuration writer for an array of `NUM_CELLS` logic cells. It accepts a bit-serial configuration stream under a valid/ready handshake and assembles the 16-bit `lFragBitInfo` word for each cell. Each word is held in a shadow register that drives the cells' LUT configuration inputs. It sits between the bitstream source and the logic-cell array, and is the producer for the cells' configuration-consuming input.

## Interface
Parameters:
- `NUM_CELLS`, 4: number of cells driven; legal range 1..16.
- `DATA_BITS`, 16: configuration word width per cell; fixed by the cell definition.

Ports:
- `QCK`  in  1  clock; all state changes on the rising edge.
- `QRT`  in  1  reset, asynchronous, active-high.
- `CFG_EN`  in  1  loader enable. Low means abort or idle.
- `SDI`  in  1  serial configuration bit.
- `SVALID`  in  1  `SDI` is valid this cycle.
- `SREADY`  out  1  loader accepts a bit this cycle.
- `CFG_BITS`  out  `NUM_CELLS*16`  shadow words; cell k occupies bits [16k+15:16k].
- `CFG_WE`  out  `NUM_CELLS`  one-hot, one-cycle pulse on the cell just updated.
- `DONE`  out  1  sticky; every cell has been written at least once since reset.
- `ERR`  out  1  sticky; a parity error or an out-of-range address has occurred.

## Operation
- Frame format is 21 bits, MSB-first:
  - 4-bit cell address;
  - 16 data bits, data[15] first;
  - 1 parity bit, chosen so the total count of ones over all 21 bits is even.
- A bit is accepted only on a cycle where `SVALID && SREADY`. `SVALID` low inserts wait cycles with no state change.
- FSM states:
  - `IDLE`: `SREADY`=0. Goes to `ADDR` when `CFG_EN`=1.
  - `ADDR`: `SREADY`=1. Shifts in 4 bits, then goes to `DATA`.
  - `DATA`: `SREADY`=1. Shifts in 16 bits, then goes to `PARITY`.
  - `PARITY`: `SREADY`=1. On acceptance of the parity bit, goes to `COMMIT`.
  - `COMMIT`: `SREADY`=0. Lasts exactly 1 cycle, then goes to `ADDR` if `CFG_EN`=1, else to `IDLE`.
- Commit rule, evaluated at the parity-accept edge:
  - If parity is good and address < `NUM_CELLS`: write the word into shadow[addr], set written[addr], and drive `CFG_WE[addr]`=1 for the COMMIT cycle only.
  - Otherwise: the shadow registers are unchanged, `CFG_WE` stays 0, and `ERR` is set. The next frame is still processed normally.
- `DONE` is the AND of the `written` flags. It remains set after further writes.
- Rewriting a cell overwrites its word and pulses its `CFG_WE` again.
- `CFG_EN` low in `ADDR`, `DATA` or `PARITY`:
  - the partial frame is discarded and the FSM goes to `IDLE` on the next edge;
  - a bit presented in that same cycle is still accepted by the handshake but is discarded;
  - shadow registers, `DONE` and `ERR` are unchanged.
- `CFG_EN` low during `COMMIT` does not cancel the commit.

## Timing
- Reset values:
  - `CFG_BITS` = all 0, meaning every LUT outputs constant 0;
  - `CFG_WE` = 0, `SREADY` = 0, `DONE` = 0, `ERR` = 0;
  - FSM in `IDLE`, bit counter 0, parity accumulator 0, `written` = 0.
- `QRT` takes effect immediately and asynchronously, including mid-frame. Release is sampled on the next `QCK` edge.
- All outputs are registered; none is combinational from inputs.
- `SREADY` rises 1 cycle after `CFG_EN` is seen high in `IDLE`.
- Latency: `CFG_BITS`/`CFG_WE` change in the cycle immediately after the parity-accept edge.
- Minimum frame period with `SVALID` held high is 22 cycles (21 accepts plus 1 `COMMIT`).
- Address-field MSB set with `NUM_CELLS` ≤ 8, or any address ≥ `NUM_CELLS`, counts as out of range and is reported through `ERR`.

## Structure
- Package `lut_cfg_pkg`:
  - state enum (`IDLE`, `ADDR`, `DATA`, `PARITY`, `COMMIT`);
  - constants `ADDR_BITS`=4, `DATA_BITS`=16, `FRAME_LEN`=21;
  - count-width localparam.
- Sub-module `lut_cfg_shifter`: 20-bit serial-to-parallel shift register with running XOR parity. It is cleared by a `clr` input and exposes `addr`, `data` and `parity_ok`.
- Top level holds:
  - the FSM and the 5-bit bit counter;
  - the shadow register array and address decode;
  - `written`/`DONE`/`ERR` logic.

## Test plan
- Reset with `NUM_CELLS`=4 → `CFG_BITS`=0, `SREADY`=0, `DONE`=0, `ERR`=0. Assert `QRT` mid-`DATA` → all outputs return to reset values immediately.
- Send frame addr=2, data=0x8000 with correct parity and `SVALID` continuous → `CFG_WE`=4'b0100 for exactly 1 cycle, `CFG_BITS[47:32]`=0x8000, other cells 0, `SREADY` low in that cycle.
- Write cells 0..3 with 0xAAAA, 0x5555, 0xF0F0, 0x0FF0 using random `SVALID` gaps → contents match, `DONE`=1 after the 4th commit and stays 1 after a rewrite of cell 1.
- Send frame addr=1 with wrong parity, then addr=5 with good parity → no `CFG_WE` for either, shadows unchanged, `ERR`=1. A subsequent good frame to addr=1 still commits.
- Drop `CFG_EN` after 10 data bits → `IDLE` on the next edge, no commit. Re-enable and send a full frame → that frame alone commits correctly.
- Back-to-back frames → `SREADY` low only in the single `COMMIT` cycle; 22-cycle period measured.

Source files
------------

// File: rtl/lut_cfg_pkg.sv
// Shared constants and FSM state type for the serial LUT configuration loader.
// A frame is a 4-bit cell address, then 16 data bits, then one even-parity bit.
package lut_cfg_pkg;

   localparam int unsigned ADDR_BITS = 4;
   localparam int unsigned DATA_BITS = 16;
   localparam int unsigned FRAME_LEN = ADDR_BITS + DATA_BITS + 1;
   localparam int unsigned SHIFT_LEN = ADDR_BITS + DATA_BITS;
   localparam int unsigned CNT_W     = $clog2(FRAME_LEN);

   typedef enum logic [2:0] {
      StIdle,
      StAddr,
      StData,
      StParity,
      StCommit
   } cfg_state_e;

endpackage

// File: rtl/lut_cfg_shifter.sv
// Serial-to-parallel shifter for the address and data fields of a frame, with
// a running XOR over every shifted bit so the parity bit can be judged on arrival.
module lut_cfg_shifter
   import lut_cfg_pkg::*;
(
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 clr,
   input  logic                 shift_en,
   input  logic                 sdi,
   output logic [ADDR_BITS-1:0] addr,
   output logic [DATA_BITS-1:0] data,
   output logic                 parity_ok
);

   logic [SHIFT_LEN-1:0] sreg_q;
   logic                 par_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sreg_q <= '0;
         par_q  <= 1'b0;
      end else if (clr) begin
         sreg_q <= '0;
         par_q  <= 1'b0;
      end else if (shift_en) begin
         sreg_q <= {sreg_q[SHIFT_LEN-2:0], sdi};
         par_q  <= par_q ^ sdi;
      end
   end

   assign addr = sreg_q[SHIFT_LEN-1 -: ADDR_BITS];
   assign data = sreg_q[DATA_BITS-1:0];

   // Folds in the parity bit currently on sdi; only meaningful in the parity slot.
   assign parity_ok = ~(par_q ^ sdi);

endmodule

// File: rtl/lut_cfg_loader.sv
// Bit-serial configuration writer: assembles framed 16-bit words and commits them
// into per-cell shadow registers that drive the logic-cell LUT configuration inputs.
module lut_cfg_loader
   import lut_cfg_pkg::*;
#(
   parameter int unsigned NUM_CELLS = 4,
   parameter int unsigned DATA_BITS = 16
) (
   input  logic                           QCK,
   input  logic                           QRT,
   input  logic                           CFG_EN,
   input  logic                           SDI,
   input  logic                           SVALID,
   output logic                           SREADY,
   output logic [NUM_CELLS*DATA_BITS-1:0] CFG_BITS,
   output logic [NUM_CELLS-1:0]           CFG_WE,
   output logic                           DONE,
   output logic                           ERR
);

   cfg_state_e                     state_q;
   logic [CNT_W-1:0]               cnt_q;
   logic                           sready_q;
   logic [NUM_CELLS-1:0]           we_q;
   logic [NUM_CELLS*DATA_BITS-1:0] bits_q;
   logic [NUM_CELLS-1:0]           written_q;
   logic                           done_q;
   logic                           err_q;

   logic                           accept;
   logic                           shift_en;
   logic                           sh_clr;
   logic                           commit;
   logic                           addr_ok;
   logic                           commit_ok;
   logic                           commit_bad;
   logic [NUM_CELLS-1:0]           we_vec;
   logic [ADDR_BITS-1:0]           sh_addr;
   logic [DATA_BITS-1:0]           sh_data;
   logic                           sh_parity_ok;

   lut_cfg_shifter u_shifter (
      .clk       (QCK),
      .rst       (QRT),
      .clr       (sh_clr),
      .shift_en  (shift_en),
      .sdi       (SDI),
      .addr      (sh_addr),
      .data      (sh_data),
      .parity_ok (sh_parity_ok)
   );

   always_comb begin
      accept     = SVALID & sready_q;
      shift_en   = accept && CFG_EN && (state_q == StAddr || state_q == StData);
      // Idle, commit and an abort all leave the next frame starting from a clean shifter.
      sh_clr     = (state_q == StIdle) || (state_q == StCommit) || !CFG_EN;
      commit     = accept && CFG_EN && (state_q == StParity);
      addr_ok    = 32'(sh_addr) < NUM_CELLS;
      commit_ok  = commit && sh_parity_ok && addr_ok;
      commit_bad = commit && !(sh_parity_ok && addr_ok);
      we_vec     = '0;
      for (int unsigned k = 0; k < NUM_CELLS; k++) begin
         we_vec[k] = commit_ok && (32'(sh_addr) == k);
      end
   end

   always_ff @(posedge QCK or posedge QRT) begin
      if (QRT) begin
         state_q  <= StIdle;
         cnt_q    <= '0;
         sready_q <= 1'b0;
         we_q     <= '0;
      end else begin
         we_q <= '0;
         unique case (state_q)
            StIdle: begin
               if (CFG_EN) begin
                  state_q  <= StAddr;
                  sready_q <= 1'b1;
                  cnt_q    <= '0;
               end
            end
            StAddr, StData, StParity: begin
               if (!CFG_EN) begin
                  state_q  <= StIdle;
                  sready_q <= 1'b0;
                  cnt_q    <= '0;
               end else if (accept) begin
                  cnt_q <= cnt_q + CNT_W'(1);
                  if (state_q == StAddr && cnt_q == CNT_W'(ADDR_BITS - 1)) begin
                     state_q <= StData;
                  end
                  if (state_q == StData && cnt_q == CNT_W'(SHIFT_LEN - 1)) begin
                     state_q <= StParity;
                  end
                  if (state_q == StParity) begin
                     state_q  <= StCommit;
                     sready_q <= 1'b0;
                     we_q     <= we_vec;
                     cnt_q    <= '0;
                  end
               end
            end
            StCommit: begin
               state_q  <= CFG_EN ? StAddr : StIdle;
               sready_q <= CFG_EN;
               cnt_q    <= '0;
            end
            default: begin
               state_q  <= StIdle;
               sready_q <= 1'b0;
               cnt_q    <= '0;
            end
         endcase
      end
   end

   always_ff @(posedge QCK or posedge QRT) begin
      if (QRT) begin
         bits_q    <= '0;
         written_q <= '0;
         done_q    <= 1'b0;
         err_q     <= 1'b0;
      end else begin
         for (int unsigned k = 0; k < NUM_CELLS; k++) begin
            if (we_vec[k]) begin
               bits_q[k*DATA_BITS +: DATA_BITS] <= sh_data;
            end
         end
         written_q <= written_q | we_vec;
         // Looks ahead at this commit so DONE rises together with the final CFG_WE.
         if (&(written_q | we_vec)) begin
            done_q <= 1'b1;
         end
         if (commit_bad) begin
            err_q <= 1'b1;
         end
      end
   end

   assign SREADY   = sready_q;
   assign CFG_WE   = we_q;
   assign CFG_BITS = bits_q;
   assign DONE     = done_q;
   assign ERR      = err_q;

endmodule
